// File: rtl/req_matrix_vc_pipe.sv
// Registered, VC-aware request matrix: per input, picks a full VC round-robin,
// latches its XY route and hop-updated packet, and holds one request until granted.
module req_matrix_vc_pipe #(
  parameter int unsigned DW    = 64,
  parameter int unsigned NVC   = 2,
  parameter int unsigned AGE_W = 4,
  localparam int unsigned VCW  = (NVC > 1) ? $clog2(NVC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5*NVC-1:0]      in_full,
  input  logic [5*NVC*DW-1:0]   in_q,
  input  logic [4:0]            gnt,
  output logic [4:0]            req_to_n,
  output logic [4:0]            req_to_s,
  output logic [4:0]            req_to_e,
  output logic [4:0]            req_to_w,
  output logic [4:0]            req_to_pe,
  output logic [5*DW-1:0]       pkt_next,
  output logic [5*VCW-1:0]      sel_vc,
  output logic [5*NVC-1:0]      pop,
  output logic [4:0]            urgent
);

  localparam int unsigned NI = 5;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  for (genvar gi = 0; gi < NI; gi++) begin : g_in
    state_t                  state_q, state_d;
    logic [VCW-1:0]          rr_q, rr_d;
    logic [VCW-1:0]          vc_q, vc_d;
    logic [4:0]              route_q, route_d;
    logic [DW-1:0]           pkt_q, pkt_d;
    logic [AGE_W-1:0]        age_q, age_d;
    logic                    urg_q, urg_d;
    logic [NVC-1:0]          full;
    logic [NVC-1:0][DW-1:0]  q;
    logic [NVC-1:0]          held_sh;
    logic                    held_full;
    logic                    any_full;
    logic [VCW-1:0]          pick;
    logic [DW-1:0]           pick_pkt;
    logic [DW-1:0]           pick_next;
    logic [4:0]              pick_route;

    assign full      = in_full[gi*NVC +: NVC];
    assign q         = in_q[gi*NVC*DW +: NVC*DW];
    assign held_sh   = full >> vc_q;
    assign held_full = held_sh[0];
    assign pick_pkt  = q[pick];

    // First full VC at or after rr_q, wrapping upward.
    always_comb begin
      logic [NVC-1:0] sh;
      int unsigned    idx;
      pick     = rr_q;
      any_full = 1'b0;
      sh       = '0;
      idx      = 0;
      for (int unsigned k = 0; k < NVC; k++) begin
        idx = (32'(rr_q) + k) % NVC;
        sh  = full >> idx;
        if (sh[0] && !any_full) begin
          pick     = VCW'(idx);
          any_full = 1'b1;
        end
      end
    end

    // XY decode; route bit index follows input numbering (N=4 .. PE=0).
    always_comb begin
      logic [3:0] hx;
      logic [3:0] hy;
      hx         = pick_pkt[55:52];
      hy         = pick_pkt[51:48];
      pick_next  = pick_pkt;
      pick_route = 5'b00001;
      if (hx != 4'd0) begin
        pick_route       = pick_pkt[62] ? 5'b00010 : 5'b00100;
        pick_next[55:52] = hx >> 1;
      end else if (hy != 4'd0) begin
        pick_route       = pick_pkt[61] ? 5'b01000 : 5'b10000;
        pick_next[51:48] = hy >> 1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        rr_q    <= '0;
        vc_q    <= '0;
        route_q <= '0;
        pkt_q   <= '0;
        age_q   <= '0;
        urg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rr_q    <= rr_d;
        vc_q    <= vc_d;
        route_q <= route_d;
        pkt_q   <= pkt_d;
        age_q   <= age_d;
        urg_q   <= urg_d;
      end
    end

    // A grant wins over a simultaneous flush of the held VC.
    always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      vc_d    = vc_q;
      route_d = route_q;
      pkt_d   = pkt_q;
      age_d   = age_q;
      urg_d   = urg_q;
      case (state_q)
        S_IDLE: begin
          if (any_full) begin
            state_d = S_REQ;
            vc_d    = pick;
            route_d = pick_route;
            pkt_d   = pick_next;
            age_d   = '0;
            urg_d   = 1'b0;
          end
        end
        S_REQ: begin
          if (gnt[gi]) begin
            state_d = S_IDLE;
            route_d = '0;
            rr_d    = VCW'((32'(vc_q) + 32'd1) % NVC);
            age_d   = '0;
            urg_d   = 1'b0;
          end else if (held_full) begin
            if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
            urg_d = (age_d == AGE_MAX);
          end else begin
            state_d = S_IDLE;
            route_d = '0;
            age_d   = '0;
            urg_d   = 1'b0;
          end
        end
      endcase
    end

    assign pop[gi*NVC +: NVC] = (state_q == S_REQ && gnt[gi]) ? (NVC'(1) << vc_q) : '0;
    assign req_to_n[gi]       = route_q[4];
    assign req_to_s[gi]       = route_q[3];
    assign req_to_e[gi]       = route_q[2];
    assign req_to_w[gi]       = route_q[1];
    assign req_to_pe[gi]      = route_q[0];
    assign pkt_next[gi*DW +: DW]   = pkt_q;
    assign sel_vc[gi*VCW +: VCW]   = vc_q;
    assign urgent[gi]              = urg_q;
  end

endmodule

// File: doc/req_matrix_vc_pipe.md
Name: req_matrix_vc_pipe

Overview:
- Registered, VC-aware successor to the combinational request matrix.
- Each of the five inputs (N,S,E,W,PE) holds NVC VC buffers. Per input, the block selects one full VC round-robin and latches its header-derived XY route and hop-updated packet.
- It holds a single request toward the target output until the switch allocator grants it, then pops that VC buffer.
- A saturating age counter per input flags starving requests to the allocator.

Parameters:
- DW, 64, packet width. Header layout fixed in bits [63:32]: [63] vc, [62] dx, [61] dy, [60:56] rsv, [55:52] hx, [51:48] hy, [47:40] srcx, [39:32] srcy.
- NVC, 2, VCs per input (≥1). VCW = (NVC>1) ? clog2(NVC) : 1.
- AGE_W, 4, age counter width (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_full  in  5*NVC  VC buffer full; input index i (N=4,S=3,E=2,W=1,PE=0), VC v at bit i*NVC+v
- in_q  in  5*NVC*DW  VC buffer data, slot i*NVC+v at bits [(i*NVC+v)*DW +: DW]
- gnt  in  5  per-input grant from switch allocator; bit i = input i's held request granted
- req_to_n, req_to_s, req_to_e, req_to_w, req_to_pe  out  5 each  per-output request vectors; bit i = input i
- pkt_next  out  5*DW  latched hop-updated packet per input, [i*DW +: DW]
- sel_vc  out  5*VCW  latched VC index per input
- pop  out  5*NVC  one-cycle dequeue strobe per VC buffer
- urgent  out  5  age saturated for input i

Behaviour:
- Reset: all inputs go to IDLE. All req_to_*, pkt_next, sel_vc, pop and urgent are 0. The rr_ptr and age counter of every input are 0.
- Route decode, shared with current XY semantics:
  - hx≠0: route E if dx=0, W if dx=1. hx_next = hx>>1, hy unchanged.
  - hx=0, hy≠0: route N if dy=0, S if dy=1. hy_next = hy>>1.
  - hx=hy=0: route PE, fields unchanged.
  - pkt_next equals the input packet with only [55:48] replaced. All other bits are preserved.
- Per-input FSM, two states:
  - IDLE: if any in_full bit of this input is set, select the first full VC at or after rr_ptr, searching upward with wrap. On the clock edge, latch sel_vc, the decoded one-hot output route and pkt_next, and go to REQ. Otherwise stay in IDLE.
  - REQ:
    - req bit i is asserted on exactly one req_to_* output (the latched route) and on no other. Latency is 1 cycle from in_full rising in IDLE to the request becoming visible.
    - gnt[i]=1: pop[i*NVC+sel_vc] is asserted combinationally that same cycle. Next edge: go to IDLE, rr_ptr = (sel_vc+1) mod NVC, age cleared.
    - gnt[i]=0 and the latched VC's in_full still 1: age += 1, saturating at 2^AGE_W−1. urgent[i] = (age == all-ones), registered.
    - Latched VC's in_full drops without a grant (flush): drop the request, go to IDLE next edge, no pop, rr_ptr unchanged, age cleared.
- gnt[i] while input i is in IDLE is ignored: no pop and no state change.
- Latched data does not track in_q changes while in REQ. in_q is sampled only on IDLE→REQ.
- Back-to-back: after a grant, the earliest next request from the same input is visible 2 cycles after the grant cycle.
- Inputs are fully independent. Simultaneous grants to several inputs each pop their own VC in the same cycle.
- U-turn routes are not filtered; they are requested as decoded.
- Reset asserted mid-REQ: the request drops on the next edge and no pop is issued.
- pop is purely a function of registered state and gnt, with no combinational path from in_q.

Test Plan:
- PE input, VC0 full, header hx=4'b0011, dx=0, hy=0 → cycle+1: req_to_e=5'b00001. pkt_next[55:52]=4'b0001 and bits [63:56], [51:0] unchanged. gnt[0]=1 → pop[0]=1 for one cycle, then IDLE.
- N input, hx=0, hy=4'b0001, dy=1 → req_to_s[4]=1. After a grant, hy_next=0. A following packet with hx=hy=0 → req_to_pe[4]=1.
- NVC=2, W input with both VCs continuously full and gnt held high → sel_vc alternates 0,1,0,1. pop alternates bits 2 and 3. A new request appears every 2 cycles.
- AGE_W=4, request held with gnt=0 → urgent rises after 15 waiting cycles and stays at saturation. A grant clears age and urgent.
- in_full of the latched VC drops while in REQ → request removed next cycle, pop never asserted, rr_ptr unchanged.
- Grants to all five inputs in the same cycle, plus reset asserted mid-REQ on a second run → five independent pops in the first run. In the second run, all outputs are 0 after the reset edge.
